risk_tile_mem: RTL and testbench

- Parametrised successor of the RISK strided tile memory: gathers (load) or scatters (store) an SZ x SZ tile of DW-bit elements across NBANK single-port BRAM banks.
- Element addresses are addr + stride_x*x + stride_y*y.
- Adds a valid/ready request handshake, a response strobe, multi-pass serialisation of bank conflicts, and read broadcast / write last-writer merging of duplicate addresses.
- Sits between the RISK register file/sequencer and on-chip tensor storage.

---
 rtl/risk_tile_mem_if.sv | 40 ++++
 rtl/risk_tile_mem.sv | 195 +++++++++++++++++++
 tb/tb_risk_tile_mem.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/risk_tile_mem_if.sv
// ---------------------------------------------------------------------------
// risk_tile_mem_if
// Request/response bundle between the RISK sequencer and risk_tile_mem.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_we              : 1 = store tile, 0 = load tile
//   req_addr            : base element address (AW bits)
//   req_stride_x/_y     : element strides (SW bits, zero-extended)
//   req_wdata           : store data, element k = y*SZ+x at [k*DW +: DW]
//   rsp_valid           : one-cycle completion strobe
//   rsp_rdata           : load data, same packing, held until next load
//   busy                : request in flight
// master = requester side, slave = tile memory side.
// ---------------------------------------------------------------------------
interface risk_tile_mem_if #(
    parameter int SZ = 4,
    parameter int DW = 18,
    parameter int AW = 15,
    parameter int SW = 14
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AW-1:0]         req_addr;
    logic [SW-1:0]         req_stride_x;
    logic [SW-1:0]         req_stride_y;
    logic [SZ*SZ*DW-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [SZ*SZ*DW-1:0]   rsp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/risk_tile_mem.sv
// ---------------------------------------------------------------------------
// risk_tile_mem
// Strided SZ x SZ tile gather/scatter over NBANK single-port BRAM banks.
// Element k = y*SZ+x lives at e_k = addr + sx*x + sy*y (mod 2^AW);
// bank = e_k[BW-1:0], row = e_k[AW-1:BW]. Bank conflicts are serialised
// into passes; duplicate addresses are broadcast on loads and merged on
// stores (highest element index wins).
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   bus         : risk_tile_mem_if.slave (request handshake + response)
// Optional (macro RISK_TILE_MEM_CONFLICT_STATS_EN):
//   conflict_cnt : saturating sum of (P-1) over completed requests
//   last_passes  : pass count P of the most recent completed request
// ---------------------------------------------------------------------------
module risk_tile_mem #(
    parameter int SZ     = 4,
    parameter int NBANK  = 32,
    parameter int BDEPTH = 1024,
    parameter int DW     = 18,
    parameter int BW     = $clog2(NBANK),
    parameter int AW     = BW + $clog2(BDEPTH),
    parameter int SW     = AW - 1
) (
    input  logic            clk,
    input  logic            resetn,
    risk_tile_mem_if.slave  bus
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
    ,
    output logic [31:0]                  conflict_cnt,
    output logic [$clog2(SZ*SZ+1)-1:0]   last_passes
`endif
);
    localparam int N  = SZ * SZ;
    localparam int RW = AW - BW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]             r_state;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [SW-1:0]          r_sx, r_sy;
    logic [N-1:0][DW-1:0]   r_wdata;
    logic [N-1:0][AW-1:0]   r_e;
    logic [N-1:0]           r_pend;
    logic [N-1:0]           r_svc;      // load elements issued last cycle
    logic [N-1:0][DW-1:0]   r_gbuf;
    logic [N-1:0][DW-1:0]   r_rdata;

    logic [N-1:0][AW-1:0]   w_e;
    logic [N-1:0]           w_lead;
    logic [N-1:0]           w_svc;
    logic [N-1:0]           w_rem;
    logic [NBANK-1:0]       w_ben;
    logic [RW-1:0]          w_brow [NBANK];
    logic [DW-1:0]          w_bwd  [NBANK];
    logic [DW-1:0]          w_brd  [NBANK];
    logic [N-1:0][DW-1:0]   w_gnext;

    // Element addresses from the latched request; wrap is silent.
    always_comb begin
        w_e = '0;
        for (int y = 0; y < SZ; y++)
            for (int x = 0; x < SZ; x++)
                w_e[y*SZ+x] = r_addr + AW'(r_sx) * AW'(x) + AW'(r_sy) * AW'(y);
    end

    // Leader = lowest-index pending element on its bank. Every pending
    // element sharing a leader's full address rides along in the same pass.
    always_comb begin
        w_lead = '0;
        w_svc  = '0;
        for (int k = 0; k < N; k++) begin
            w_lead[k] = r_pend[k];
            for (int j = 0; j < N; j++)
                if (j < k && r_pend[j] && r_e[j][BW-1:0] == r_e[k][BW-1:0])
                    w_lead[k] = 1'b0;
        end
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                if (r_pend[k] && w_lead[j] && r_e[j] == r_e[k])
                    w_svc[k] = 1'b1;
    end

    assign w_rem = r_pend & ~w_svc;

    // Bank commands. Ascending scan: the highest serviced index on a bank
    // supplies the write data (all of them share one address).
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            w_ben[b]  = 1'b0;
            w_brow[b] = '0;
            w_bwd[b]  = '0;
            for (int k = 0; k < N; k++)
                if (w_svc[k] && r_e[k][BW-1:0] == BW'(b)) begin
                    w_ben[b]  = resetn && (r_state == S_ISSUE);
                    w_brow[b] = r_e[k][AW-1:BW];
                    w_bwd[b]  = r_wdata[k];
                end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < NBANK; gb++) begin : g_bank
            logic [DW-1:0] mem [BDEPTH];
            logic [DW-1:0] r_rd;
            always_ff @(posedge clk) begin
                if (w_ben[gb]) begin
                    if (r_we) mem[w_brow[gb]] <= w_bwd[gb];
                    else      r_rd <= mem[w_brow[gb]];
                end
            end
            assign w_brd[gb] = r_rd;
        end
    endgenerate

    // Gather: last cycle's serviced elements take their bank's read data;
    // duplicates pick up the same word (broadcast).
    always_comb begin
        w_gnext = r_gbuf;
        for (int k = 0; k < N; k++)
            if (r_svc[k]) w_gnext[k] = w_brd[r_e[k][BW-1:0]];
    end

`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
    logic [$clog2(N+1)-1:0] r_pass;
    logic [32:0]            w_ccsum;
    assign w_ccsum = {1'b0, conflict_cnt} + 33'(r_pass) - 33'd1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_svc   <= '0;
            r_rdata <= '0;
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
            r_pass       <= '0;
            conflict_cnt <= '0;
            last_passes  <= '0;
`endif
        end else begin
            r_svc  <= '0;
            r_gbuf <= w_gnext;
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_we    <= bus.req_we;
                    r_addr  <= bus.req_addr;
                    r_sx    <= bus.req_stride_x;
                    r_sy    <= bus.req_stride_y;
                    r_wdata <= bus.req_wdata;
                    r_state <= S_ADDR;
                end
                S_ADDR: begin
                    r_e     <= w_e;
                    r_pend  <= '1;
                    r_state <= S_ISSUE;
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
                    r_pass  <= '0;
`endif
                end
                S_ISSUE: begin
                    r_pend <= w_rem;
                    if (!r_we) r_svc <= w_svc;
                    if (w_rem == '0) r_state <= r_we ? S_RESP : S_DRAIN;
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
                    r_pass <= r_pass + 1'b1;
`endif
                end
                S_DRAIN: begin
                    r_rdata <= w_gnext;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
                    last_passes  <= r_pass;
                    conflict_cnt <= w_ccsum[32] ? 32'hFFFF_FFFF : w_ccsum[31:0];
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_risk_tile_mem.sv
module tb_risk_tile_mem;
    localparam int SZ = 4, NBANK = 32, BDEPTH = 1024, DW = 18;
    localparam int AW = 15, SW = 14, N = SZ*SZ, TW = N*DW;

    typedef struct {
        logic          we;
        int unsigned   cyc;
        logic [TW-1:0] data;
        logic [TW-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    risk_tile_mem_if #(.SZ(SZ), .DW(DW), .AW(AW), .SW(SW)) bus();

`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
    logic [31:0] conflict_cnt;
    logic [4:0]  last_passes;
`endif

    risk_tile_mem #(.SZ(SZ), .NBANK(NBANK), .BDEPTH(BDEPTH), .DW(DW)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
        , .conflict_cnt(conflict_cnt)
        , .last_passes(last_passes)
`endif
    );

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [int unsigned];
    exp_t sb_q[$];
    longint unsigned ref_cc = 0;
    int ref_lp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issue one request; the model is updated and the expectation queued.
    task automatic do_req(input logic we, input int unsigned a, input int unsigned sx,
                          input int unsigned sy, input logic [TW-1:0] wd,
                          input bit expect_rsp, output int unsigned hs);
        exp_t e;
        int unsigned ad[N];
        int cnt[NBANK];
        int p, n;
        for (int b = 0; b < NBANK; b++) cnt[b] = 0;
        for (int k = 0; k < N; k++)
            ad[k] = (a + sx*(k % SZ) + sy*(k / SZ)) & 32'h7FFF;
        for (int k = 0; k < N; k++) begin
            bit dup;
            dup = 0;
            for (int j = 0; j < k; j++) if (ad[j] == ad[k]) dup = 1;
            if (!dup) cnt[ad[k] % NBANK]++;
        end
        p = 0;
        for (int b = 0; b < NBANK; b++) if (cnt[b] > p) p = cnt[b];
        e.we = we;
        e.data = '0;
        e.mask = '0;
        if (we) begin
            for (int k = 0; k < N; k++) ref_mem[ad[k]] = wd[k*DW +: DW];
        end else begin
            for (int k = 0; k < N; k++)
                if (ref_mem.exists(ad[k])) begin
                    e.data[k*DW +: DW] = ref_mem[ad[k]];
                    e.mask[k*DW +: DW] = '1;
                end
        end
        hs = 0;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got busy want ready");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_addr = AW'(a);
        bus.req_stride_x = SW'(sx);
        bus.req_stride_y = SW'(sy);
        bus.req_wdata = wd;
        hs = cyc;
        e.cyc = cyc + (we ? p + 2 : p + 3);
        if (expect_rsp) begin
            sb_q.push_back(e);
            ref_cc += longint'(p - 1);
            ref_lp = p;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Monitor: every response strobe pops one expectation.
    always @(negedge clk) begin
        if (resetn && bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rsp: got rsp_valid want none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL latency: got cycle %0d want %0d", cyc, e.cyc);
                end
                if (!e.we) begin
                    total++;
                    if ((bus.rsp_rdata & e.mask) !== e.data) begin
                        bad++;
                        $display("FAIL rdata: got %h want %h", bus.rsp_rdata & e.mask, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [TW-1:0] mk_data(input int base, input int step, input int modv);
        logic [TW-1:0] d;
        d = '0;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(base + step * (k % modv));
        return d;
    endfunction

    initial begin
        int unsigned hs;
        logic [TW-1:0] wd;
        int n;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_stride_x = '0;
        bus.req_stride_y = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rdata", 64'(|bus.rsp_rdata), 64'd0);
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif

        // Conflict-free store/load: element k = k+1
        do_req(1'b1, 0, 1, 4, mk_data(1, 1, N), 1'b1, hs);
        @(negedge clk);
        chk("busy_in_flight", 64'(bus.busy), 64'd1);
        do_req(1'b0, 0, 1, 4, '0, 1'b1, hs);
        // All 16 elements on bank 5, distinct rows -> 16 passes
        do_req(1'b1, 5, 32, 128, mk_data(500, 3, N), 1'b1, hs);
        do_req(1'b0, 5, 32, 128, '0, 1'b1, hs);
        // Broadcast of a single word
        do_req(1'b1, 7, 0, 0, mk_data(32'h2A5, 0, 1), 1'b1, hs);
        do_req(1'b0, 7, 0, 0, '0, 1'b1, hs);
        // Last writer wins: every element targets addr 9
        do_req(1'b1, 9, 0, 0, mk_data(100, 1, N), 1'b1, hs);
        do_req(1'b0, 9, 0, 0, '0, 1'b1, hs);
        // Wrap-around at the top of the address space
        do_req(1'b1, 32'h7FFF, 1, 0, mk_data(1, 1, SZ), 1'b1, hs);
        do_req(1'b0, 32'h7FFF, 1, 0, '0, 1'b1, hs);
        do_req(1'b0, 0, 1, 1, '0, 1'b1, hs);

        // Abort a conflicting load with reset in cycle 6
        do_req(1'b0, 5, 32, 128, '0, 1'b0, hs);
        n = 0;
        while (cyc < hs + 6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ref_cc = 0;
        @(negedge clk);
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_rdata", 64'(|bus.rsp_rdata), 64'd0);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        do_req(1'b0, 5, 32, 128, '0, 1'b1, hs);

        // Randomized mix over a small window so loads hit written data
        for (int i = 0; i < 40; i++) begin
            logic we;
            int unsigned a, sx, sy;
            we = ($urandom_range(0, 1) == 1);
            a  = $urandom_range(0, 300);
            sx = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h3FFF) : $urandom_range(0, 40);
            sy = ($urandom_range(0, 3) == 0) ? 32 * $urandom_range(0, 8) : $urandom_range(0, 40);
            for (int k = 0; k < N; k++) wd[k*DW +: DW] = DW'($urandom);
            do_req(we, a, sx, sy, wd, 1'b1, hs);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 64'(sb_q.size()), 64'd0);
`ifdef RISK_TILE_MEM_CONFLICT_STATS_EN
        @(negedge clk);
        chk("conflict_cnt", 64'(conflict_cnt), 64'(ref_cc[31:0]));
        chk("last_passes", 64'(last_passes), 64'(ref_lp));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end
endmodule
